// File: rtl/multicycle_control.sv
// multicycle_control: sequencer for the 16-bit, 4-register multicycle MIPS
// datapath. It shares one ALU and one memory port across the fetch, decode,
// execute, memory and write-back steps. Outputs are decoded from the current
// state. The only exceptions are the mem_ready, op and zero qualified strobes.
module multicycle_control #(
   parameter logic [15:0] RESET_COUNT = 16'h0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  op,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_src,
   output logic        ir_write,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_ctl,
   output logic [3:0]  state,
   output logic        instr_done,
   output logic [15:0] instr_count,
   output logic        illegal
);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_EXEC_R = 4'd2;
   localparam logic [3:0] S_RWB    = 4'd3;
   localparam logic [3:0] S_ADDR   = 4'd4;
   localparam logic [3:0] S_MEMRD  = 4'd5;
   localparam logic [3:0] S_LWB    = 4'd6;
   localparam logic [3:0] S_MEMWR  = 4'd7;
   localparam logic [3:0] S_IWB    = 4'd8;
   localparam logic [3:0] S_BRANCH = 4'd9;
   localparam logic [3:0] S_TRAP   = 4'd10;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0]  state_reg;
   logic [3:0]  state_next;
   logic [15:0] count_reg;
   logic        illegal_reg;

   // Strobes before the reset override is applied.
   logic pc_write_dec;
   logic ir_write_dec;
   logic mem_read_dec;
   logic mem_write_dec;
   logic reg_write_dec;
   logic instr_done_dec;

   // Next-state and output decode for every state.
   always_comb begin
      state_next     = state_reg;
      pc_write_dec   = 1'b0;
      ir_write_dec   = 1'b0;
      mem_read_dec   = 1'b0;
      mem_write_dec  = 1'b0;
      reg_write_dec  = 1'b0;
      instr_done_dec = 1'b0;
      pc_src         = 1'b0;
      i_or_d         = 1'b0;
      reg_dst        = 1'b0;
      mem_to_reg     = 1'b0;
      alu_src_a      = 1'b0;
      alu_src_b      = 2'b00;
      alu_ctl        = ALU_ADD;
      case (state_reg)
         S_FETCH: begin
            // PC + 2 is computed while the instruction is read.
            mem_read_dec = 1'b1;
            alu_src_b    = 2'b01;
            if (mem_ready) begin
               ir_write_dec = 1'b1;
               pc_write_dec = 1'b1;
               state_next   = S_DECODE;
            end
         end
         S_DECODE: begin
            // The branch target is computed speculatively into ALUOut.
            alu_src_b = 2'b11;
            case (op)
               4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_next = S_EXEC_R;
               4'b0100, 4'b0101, 4'b0110:                   state_next = S_ADDR;
               4'b1000, 4'b1001:                            state_next = S_BRANCH;
               default:                                     state_next = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            case (op)
               4'b0001: alu_ctl = ALU_SUB;
               4'b0010: alu_ctl = ALU_AND;
               4'b0011: alu_ctl = ALU_OR;
               4'b0111: alu_ctl = ALU_SLT;
               default: alu_ctl = ALU_ADD;
            endcase
            state_next = S_RWB;
         end
         S_RWB: begin
            reg_write_dec  = 1'b1;
            reg_dst        = 1'b1;
            instr_done_dec = 1'b1;
            state_next     = S_FETCH;
         end
         S_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op)
               4'b0100: state_next = S_IWB;
               4'b0101: state_next = S_MEMRD;
               4'b0110: state_next = S_MEMWR;
               // op changed under us: treat it as an illegal instruction.
               default: state_next = S_TRAP;
            endcase
         end
         S_MEMRD: begin
            mem_read_dec = 1'b1;
            i_or_d       = 1'b1;
            if (mem_ready) state_next = S_LWB;
         end
         S_LWB: begin
            reg_write_dec  = 1'b1;
            mem_to_reg     = 1'b1;
            instr_done_dec = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEMWR: begin
            mem_write_dec = 1'b1;
            i_or_d        = 1'b1;
            if (mem_ready) begin
               instr_done_dec = 1'b1;
               state_next     = S_FETCH;
            end
         end
         S_IWB: begin
            reg_write_dec  = 1'b1;
            instr_done_dec = 1'b1;
            state_next     = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a      = 1'b1;
            alu_ctl        = ALU_SUB;
            pc_src         = 1'b1;
            instr_done_dec = 1'b1;
            pc_write_dec   = ((op == 4'b1000) && zero) || ((op == 4'b1001) && !zero);
            state_next     = S_FETCH;
         end
         S_TRAP: begin
            state_next = S_TRAP;
         end
         default: begin
            // Unused encodings fall into the trap rather than wander.
            state_next = S_TRAP;
         end
      endcase
   end

   // Reset kills every write and request immediately, including an outstanding memory access.
   assign pc_write   = pc_write_dec   & reset_n;
   assign ir_write   = ir_write_dec   & reset_n;
   assign mem_read   = mem_read_dec   & reset_n;
   assign mem_write  = mem_write_dec  & reset_n;
   assign reg_write  = reg_write_dec  & reset_n;
   assign instr_done = instr_done_dec & reset_n;

   assign state       = state_reg;
   assign instr_count = count_reg;
   assign illegal     = illegal_reg;

   // State register, retired-instruction counter and sticky trap flag.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg   <= S_FETCH;
         count_reg   <= RESET_COUNT;
         illegal_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (instr_done_dec) count_reg <= count_reg + 16'd1;
         if (state_next == S_TRAP) illegal_reg <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each task pushes the state trace
// it expects into a scoreboard queue. It then pops one entry per clock and
// compares it against the DUT. A second instance, preloaded near the counter
// limit, exercises the count wrap.
module tb_multicycle_control;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  op = 4'b0000;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;

   logic        pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
   logic        reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, illegal;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctl;
   logic [3:0]  state;
   logic [15:0] instr_count;

   logic        w_pc_write, w_pc_src, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
   logic        w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a, w_instr_done, w_illegal;
   logic [1:0]  w_alu_src_b;
   logic [2:0]  w_alu_ctl;
   logic [3:0]  w_state;
   logic [15:0] w_instr_count;

   int tests = 0;
   int fails = 0;
   logic [3:0] exp_q[$];

   always #5 clock = ~clock;

   multicycle_control dut (
      .clock(clock), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .state(state),
      .instr_done(instr_done), .instr_count(instr_count), .illegal(illegal)
   );

   multicycle_control #(.RESET_COUNT(16'hFFFF)) dut_w (
      .clock(clock), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(w_pc_write), .pc_src(w_pc_src), .ir_write(w_ir_write), .i_or_d(w_i_or_d),
      .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_write(w_reg_write),
      .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .alu_src_a(w_alu_src_a),
      .alu_src_b(w_alu_src_b), .alu_ctl(w_alu_ctl), .state(w_state),
      .instr_done(w_instr_done), .instr_count(w_instr_count), .illegal(w_illegal)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      mem_ready = 1'b0;
      tick();
      tick();
      tests++;
      if (mem_read !== 1'b0) begin
         fails++;
         $display("FAIL reset_mem_read_forced: got %b want 0", mem_read);
      end
      reset_n = 1'b1;
      #1;
      tests++;
      if (state !== 4'd0 || mem_read !== 1'b1 || instr_count !== 16'h0000 || illegal !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: got state=%0d mem_read=%b count=%h illegal=%b want 0/1/0000/0",
                  state, mem_read, instr_count, illegal);
      end
      tick();
      #1;
      tests++;
      if (state !== 4'd0 || pc_write !== 1'b0 || ir_write !== 1'b0) begin
         fails++;
         $display("FAIL reset_wait_ready: got state=%0d pc_write=%b ir_write=%b want 0/0/0",
                  state, pc_write, ir_write);
      end
      $display("[TB] reset: state=%0d count=%h", state, instr_count);
   endtask

   task automatic test_rtype_sub();
      logic [3:0] e;
      op = 4'b0001;
      zero = 1'b0;
      mem_ready = 1'b1;
      exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         #1;
         tests++;
         if (state !== e) begin
            fails++;
            $display("FAIL sub_state: got %0d want %0d", state, e);
         end
         if (e == 4'd2) begin
            tests++;
            if (alu_ctl !== 3'b110 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
               fails++;
               $display("FAIL sub_exec: got alu_ctl=%b src_a=%b src_b=%b want 110/1/00",
                        alu_ctl, alu_src_a, alu_src_b);
            end
         end
         if (e == 4'd3) begin
            tests++;
            if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0 || instr_done !== 1'b1) begin
               fails++;
               $display("FAIL sub_rwb: got rw=%b dst=%b m2r=%b done=%b want 1/1/0/1",
                        reg_write, reg_dst, mem_to_reg, instr_done);
            end
         end
         tick();
      end
      tests++;
      if (state !== 4'd0 || instr_count !== 16'd1) begin
         fails++;
         $display("FAIL sub_retire: got state=%0d count=%0d want 0/1", state, instr_count);
      end
      $display("[TB] sub: retired, count=%0d", instr_count);
   endtask

   task automatic test_lw_wait();
      logic [3:0] e;
      int waits = 0;
      int cycles = 0;
      op = 4'b0101;
      exp_q = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         mem_ready = !(e == 4'd5 && waits < 3);
         if (e == 4'd5) waits++;
         #1;
         cycles++;
         tests++;
         if (state !== e) begin
            fails++;
            $display("FAIL lw_state: cycle %0d got %0d want %0d", cycles, state, e);
         end
         if (e == 4'd5) begin
            tests++;
            if (mem_read !== 1'b1 || i_or_d !== 1'b1) begin
               fails++;
               $display("FAIL lw_memrd: got mem_read=%b i_or_d=%b want 1/1", mem_read, i_or_d);
            end
         end
         if (e == 4'd6) begin
            tests++;
            if (mem_to_reg !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 1'b0 || instr_done !== 1'b1) begin
               fails++;
               $display("FAIL lw_wb: got m2r=%b rw=%b dst=%b done=%b want 1/1/0/1",
                        mem_to_reg, reg_write, reg_dst, instr_done);
            end
         end
         tick();
      end
      mem_ready = 1'b1;
      tests++;
      if (state !== 4'd0 || instr_count !== 16'd2) begin
         fails++;
         $display("FAIL lw_retire: got state=%0d count=%0d want 0/2", state, instr_count);
      end
      $display("[TB] lw: %0d cycles, count=%0d", cycles, instr_count);
   endtask

   task automatic test_branch();
      logic [3:0] e;
      logic exp_pcw;
      for (int k = 0; k < 2; k++) begin
         op = (k == 0) ? 4'b1000 : 4'b1001;
         zero = 1'b1;
         exp_pcw = (k == 0);
         mem_ready = 1'b1;
         exp_q = '{4'd0, 4'd1, 4'd9};
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            #1;
            tests++;
            if (state !== e) begin
               fails++;
               $display("FAIL br_state: op=%b got %0d want %0d", op, state, e);
            end
            if (e == 4'd9) begin
               tests++;
               if (pc_write !== exp_pcw || pc_src !== 1'b1 || alu_ctl !== 3'b110 || instr_done !== 1'b1) begin
                  fails++;
                  $display("FAIL br_exec: op=%b got pcw=%b src=%b alu=%b done=%b want %b/1/110/1",
                           op, pc_write, pc_src, alu_ctl, instr_done, exp_pcw);
               end
            end
            tick();
         end
         tests++;
         if (state !== 4'd0 || instr_count !== 16'(3 + k)) begin
            fails++;
            $display("FAIL br_retire: op=%b got state=%0d count=%0d want 0/%0d", op, state, instr_count, 3 + k);
         end
         $display("[TB] branch op=%b: count=%0d", op, instr_count);
      end
      zero = 1'b0;
   endtask

   task automatic test_trap();
      op = 4'b1111;
      mem_ready = 1'b1;
      tick();
      tests++;
      if (state !== 4'd1) begin
         fails++;
         $display("FAIL trap_decode: got %0d want 1", state);
      end
      tick();
      for (int i = 0; i < 10; i++) begin
         #1;
         tests++;
         if (state !== 4'd10 || illegal !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0 ||
             pc_write !== 1'b0 || reg_write !== 1'b0 || ir_write !== 1'b0 || instr_done !== 1'b0 ||
             instr_count !== 16'd4) begin
            fails++;
            $display("FAIL trap_hold: cycle %0d got state=%0d illegal=%b mr=%b mw=%b pcw=%b rw=%b count=%0d",
                     i, state, illegal, mem_read, mem_write, pc_write, reg_write, instr_count);
         end
         tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      tests++;
      if (state !== 4'd0 || illegal !== 1'b0 || instr_count !== 16'd0) begin
         fails++;
         $display("FAIL trap_clear: got state=%0d illegal=%b count=%0d want 0/0/0", state, illegal, instr_count);
      end
      $display("[TB] trap: cleared by reset");
   endtask

   task automatic test_addi_wrap();
      logic [3:0] e;
      op = 4'b0100;
      mem_ready = 1'b1;
      tests++;
      if (w_instr_count !== 16'hFFFF) begin
         fails++;
         $display("FAIL wrap_preload: got %h want FFFF", w_instr_count);
      end
      exp_q = '{4'd0, 4'd1, 4'd4, 4'd8};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         #1;
         tests++;
         if (state !== e) begin
            fails++;
            $display("FAIL addi_state: got %0d want %0d", state, e);
         end
         if (e == 4'd8) begin
            tests++;
            if (reg_write !== 1'b1 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0 || instr_done !== 1'b1) begin
               fails++;
               $display("FAIL addi_wb: got rw=%b dst=%b m2r=%b done=%b want 1/0/0/1",
                        reg_write, reg_dst, mem_to_reg, instr_done);
            end
         end
         tick();
      end
      tests++;
      if (w_instr_count !== 16'h0000 || instr_count !== 16'd1) begin
         fails++;
         $display("FAIL wrap_count: got wrap=%h main=%h want 0000/0001", w_instr_count, instr_count);
      end
      $display("[TB] addi: wrap count=%h", w_instr_count);
   endtask

   task automatic test_back_to_back_sw();
      logic [3:0] e;
      op = 4'b0110;
      // First store completes normally, then a second one is reset in MEMWR.
      for (int k = 0; k < 2; k++) begin
         exp_q = '{4'd0, 4'd1, 4'd4, 4'd7};
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = !(k == 1 && e == 4'd7);
            #1;
            tests++;
            if (state !== e) begin
               fails++;
               $display("FAIL sw_state: store %0d got %0d want %0d", k, state, e);
            end
            if (e == 4'd7) begin
               tests++;
               if (mem_write !== 1'b1 || i_or_d !== 1'b1 || instr_done !== (k == 0)) begin
                  fails++;
                  $display("FAIL sw_memwr: store %0d got mw=%b i_or_d=%b done=%b", k, mem_write, i_or_d, instr_done);
               end
               if (k == 1) begin
                  reset_n = 1'b0;
                  #1;
                  tests++;
                  if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
                     fails++;
                     $display("FAIL sw_reset_drop: got mw=%b done=%b want 0/0", mem_write, instr_done);
                  end
               end
            end
            tick();
         end
         if (k == 0) begin
            tests++;
            if (state !== 4'd0 || instr_count !== 16'd2) begin
               fails++;
               $display("FAIL sw_retire: got state=%0d count=%0d want 0/2", state, instr_count);
            end
         end
      end
      tests++;
      if (state !== 4'd0 || instr_count !== 16'd0) begin
         fails++;
         $display("FAIL sw_reset_state: got state=%0d count=%0d want 0/0", state, instr_count);
      end
      reset_n = 1'b1;
      $display("[TB] sw: reset during MEMWR, state=%0d", state);
   endtask

   initial begin
      test_reset();
      test_rtype_sub();
      test_lw_wait();
      test_branch();
      test_trap();
      test_addi_wrap();
      test_back_to_back_sw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
